mem_stage: RTL and testbench

- Memory-access stage between the XM pipeline latch and the MW latch of the 5-stage processor.
- Issues lw/sw requests to a variable-latency data memory over a req/ready handshake.
- Stalls upstream while an access is outstanding and feeds MW with PC, instruction and write-back data, or a nop bubble.
- Exports the stage's destination register and data for XM->X bypassing.

---
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 tb/tb_mem_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage between the XM and MW latches: issues lw/sw over a
// req/ready handshake, stalls upstream while an access is outstanding.
module mem_stage #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned WAIT_WIDTH = 4,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [31:0]           PC_in,
    input  logic [31:0]           Instruction_in,
    input  logic [31:0]           alu_result,
    input  logic [31:0]           store_data,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [31:0]           dmem_rdata,
    output logic                  stall_out,
    output logic                  mw_enable,
    output logic [31:0]           PC_out,
    output logic [31:0]           Instruction_out,
    output logic [31:0]           wdata_out,
    output logic [4:0]            Rd_XM_bypass,
    output logic                  bypass_valid,
    output logic                  mem_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 5;

    localparam logic [OP_W-1:0]  OP_LW      = 5'b01000;
    localparam logic [OP_W-1:0]  OP_SW      = 5'b00111;
    localparam logic [OP_W-1:0]  OP_JAL     = 5'b00011;
    localparam logic [OP_W-1:0]  OP_SETX    = 5'b10101;
    localparam logic [REG_W-1:0] REG_LINK   = 5'd31;
    localparam logic [REG_W-1:0] REG_STATUS = 5'd30;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [WAIT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]      pc_q, pc_d;
    logic [DATA_W-1:0]      instr_q, instr_d;
    logic [DATA_W-1:0]      sdata_q, sdata_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic                   err_q, err_d;

    logic [OP_W-1:0]        op_in;
    logic                   mem_in;
    logic                   cap_lw;
    logic                   at_limit;
    logic                   complete;

    // Destination register as seen by the bypass network; r0 never forwards.
    function automatic logic [REG_W-1:0] dest_reg(input logic [DATA_W-1:0] ins);
        logic [REG_W-1:0] rd;
        rd = ins[26:22];
        if (ins == '0) begin
            rd = '0;
        end else begin
            case (ins[31:27])
                OP_JAL:  rd = REG_LINK;
                OP_SETX: rd = REG_STATUS;
                OP_SW:   rd = '0;
                default: rd = ins[26:22];
            endcase
        end
        return rd;
    endfunction

    assign op_in    = Instruction_in[31:27];
    assign mem_in   = valid_in && ((op_in == OP_LW) || (op_in == OP_SW));
    assign cap_lw   = (instr_q[31:27] == OP_LW);
    assign at_limit = (cnt_q == WAIT_WIDTH'(MAX_WAIT));
    assign complete = (state_q == S_ACCESS) && (dmem_ready || at_limit);

    // Next-state and capture logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        sdata_d = sdata_q;
        addr_d  = addr_q;
        req_d   = req_q;
        we_d    = we_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (mem_in) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    pc_d    = PC_in;
                    instr_d = Instruction_in;
                    addr_d  = alu_result[ADDR_WIDTH-1:0];
                    sdata_d = store_data;
                    req_d   = 1'b1;
                    we_d    = (op_in == OP_SW);
                end
            end
            S_ACCESS: begin
                if (complete) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    // A ready in the limit cycle is a normal completion.
                    if (!dmem_ready) begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + WAIT_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            sdata_q <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            sdata_q <= sdata_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // MW-facing outputs: pass-through in IDLE, captured values on completion
    always_comb begin
        stall_out       = 1'b0;
        PC_out          = PC_in;
        Instruction_out = '0;
        wdata_out       = '0;
        bypass_valid    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_in) begin
                    stall_out = 1'b1;
                end else if (valid_in) begin
                    Instruction_out = Instruction_in;
                    wdata_out       = alu_result;
                    bypass_valid    = 1'b1;
                end
            end
            S_ACCESS: begin
                PC_out = pc_q;
                if (complete) begin
                    Instruction_out = instr_q;
                    bypass_valid    = cap_lw;
                    if (dmem_ready) begin
                        wdata_out = cap_lw ? dmem_rdata : DATA_W'(addr_q);
                    end
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: begin
                stall_out = 1'b0;
            end
        endcase
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = sdata_q;
    assign mem_err      = err_q;
    assign mw_enable    = 1'b1;
    assign Rd_XM_bypass = dest_reg(Instruction_out);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written multi-cycle
// sequences, then random traffic against a cycle-level reference model.
module tb_mem_stage;

    localparam int unsigned AW   = 12;
    localparam int unsigned MAXW = 15;

    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    localparam logic [31:0] ADD3 = 32'h00C0_0000;
    localparam logic [31:0] LW5  = 32'h4140_0000;
    localparam logic [31:0] LW6  = 32'h4180_0000;
    localparam logic [31:0] LW7  = 32'h41C0_0000;
    localparam logic [31:0] LW9  = 32'h4240_0000;
    localparam logic [31:0] SW2  = 32'h3880_0000;
    localparam logic [31:0] JAL  = 32'h19C0_0000;
    localparam logic [31:0] SETX = 32'hA840_0000;
    localparam logic [31:0] Z32  = 32'h0;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [31:0]   PC_in, Instruction_in, alu_result, store_data;
    logic          dmem_req, dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          dmem_ready;
    logic [31:0]   dmem_rdata;
    logic          stall_out, mw_enable;
    logic [31:0]   PC_out, Instruction_out, wdata_out;
    logic [4:0]    Rd_XM_bypass;
    logic          bypass_valid, mem_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_WIDTH(AW), .WAIT_WIDTH(4), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .PC_in(PC_in),
        .Instruction_in(Instruction_in), .alu_result(alu_result), .store_data(store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall_out(stall_out),
        .mw_enable(mw_enable), .PC_out(PC_out), .Instruction_out(Instruction_out),
        .wdata_out(wdata_out), .Rd_XM_bypass(Rd_XM_bypass), .bypass_valid(bypass_valid),
        .mem_err(mem_err)
    );

    typedef struct {
        logic        vin;
        logic [31:0] pc, ins, alu, sd;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_stall;
        logic [31:0] e_ins;
        logic        c_wd;
        logic [31:0] e_wd;
        logic [4:0]  e_rd;
        logic        c_bv, e_bv;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_mwd;
        logic        e_err;
    } vec_t;

    vec_t vecs[15];

    // Reference model state: one outstanding access at most
    bit          m_busy;
    int          m_waited;
    logic [31:0] m_pc, m_ins, m_sd;
    logic [AW-1:0] m_addr;
    bit          m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] alu, input logic [31:0] sd, input logic rdy,
                         input logic [31:0] rd);
        reset = r; valid_in = v; PC_in = pc; Instruction_in = ins;
        alu_result = alu; store_data = sd; dmem_ready = rdy; dmem_rdata = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] dest_of(input logic [31:0] ins);
        if (ins == 32'h0) return 5'd0;
        case (ins[31:27])
            OP_JAL:  return 5'd31;
            OP_SETX: return 5'd30;
            OP_SW:   return 5'd0;
            default: return ins[26:22];
        endcase
    endfunction

    task automatic model_check();
        logic [4:0] op;
        bit is_lw, done;
        op = Instruction_in[31:27];
        if (!m_busy) begin
            chk("m_req_idle", 32'(dmem_req), 32'(0));
            if (valid_in && (op == OP_LW || op == OP_SW)) begin
                chk("m_stall_issue", 32'(stall_out), 32'(1));
                chk("m_ins_issue", Instruction_out, Z32);
                chk("m_rd_issue", 32'(Rd_XM_bypass), 32'(0));
            end else if (valid_in) begin
                chk("m_stall_pass", 32'(stall_out), 32'(0));
                chk("m_ins_pass", Instruction_out, Instruction_in);
                chk("m_pc_pass", PC_out, PC_in);
                chk("m_wd_pass", wdata_out, alu_result);
                chk("m_rd_pass", 32'(Rd_XM_bypass), 32'(dest_of(Instruction_in)));
                chk("m_bv_pass", 32'(bypass_valid), 32'(1));
            end else begin
                chk("m_stall_nop", 32'(stall_out), 32'(0));
                chk("m_ins_nop", Instruction_out, Z32);
                chk("m_wd_nop", wdata_out, Z32);
                chk("m_bv_nop", 32'(bypass_valid), 32'(0));
                chk("m_rd_nop", 32'(Rd_XM_bypass), 32'(0));
            end
        end else begin
            is_lw = (m_ins[31:27] == OP_LW);
            done  = dmem_ready || (m_waited == int'(MAXW));
            chk("m_req_acc", 32'(dmem_req), 32'(1));
            chk("m_we_acc", 32'(dmem_we), 32'(!is_lw));
            chk("m_addr_acc", 32'(dmem_addr), 32'(m_addr));
            if (!is_lw) chk("m_mwd_acc", dmem_wdata, m_sd);
            if (done) begin
                chk("m_stall_done", 32'(stall_out), 32'(0));
                chk("m_pc_done", PC_out, m_pc);
                chk("m_ins_done", Instruction_out, m_ins);
                chk("m_wd_done", wdata_out, !dmem_ready ? Z32 : (is_lw ? dmem_rdata : 32'(m_addr)));
                chk("m_bv_done", 32'(bypass_valid), 32'(is_lw));
                chk("m_rd_done", 32'(Rd_XM_bypass), is_lw ? 32'(m_ins[26:22]) : 32'(0));
            end else begin
                chk("m_stall_wait", 32'(stall_out), 32'(1));
                chk("m_ins_wait", Instruction_out, Z32);
                chk("m_bv_wait", 32'(bypass_valid), 32'(0));
                chk("m_rd_wait", 32'(Rd_XM_bypass), 32'(0));
            end
        end
        chk("m_err", 32'(mem_err), 32'(m_err));
        chk("m_mw_en", 32'(mw_enable), 32'(1));
    endtask

    task automatic model_update();
        logic [4:0] op;
        op = Instruction_in[31:27];
        if (reset) begin
            m_busy = 0; m_waited = 0; m_err = 0;
        end else if (m_busy) begin
            if (dmem_ready || m_waited == int'(MAXW)) begin
                m_busy = 0;
                if (!dmem_ready) m_err = 1;
            end else begin
                m_waited++;
            end
        end else if (valid_in && (op == OP_LW || op == OP_SW)) begin
            m_busy = 1; m_waited = 0;
            m_pc = PC_in; m_ins = Instruction_in; m_sd = store_data;
            m_addr = alu_result[AW-1:0];
        end
    endtask

    task automatic do_reset();
        drive(T, F, Z32, Z32, Z32, Z32, F, Z32);
        tick();
        tick();
        drive(F, F, Z32, Z32, Z32, Z32, F, Z32);
    endtask

    initial begin
        int  nreq;
        bit  done;
        int  rdy_pct;
        logic [4:0] op;
        logic [31:0] ins;

        //            vin pc        ins   alu          sd            rdy rdata          stl ins   cwd wd             rd     cbv bv  req we  addr        mwd           err
        vecs[0]  = '{F, Z32,      Z32,  Z32,         Z32,          F, Z32,           F, Z32,  T, Z32,          5'd0,  T, F, F, F, Z32,         Z32,          F};
        vecs[1]  = '{T, 32'h100,  ADD3, 32'd7,       Z32,          F, Z32,           F, ADD3, T, 32'd7,        5'd3,  T, T, F, F, Z32,         Z32,          F};
        vecs[2]  = '{T, 32'h104,  LW5,  32'h10,      Z32,          F, Z32,           T, Z32,  F, Z32,          5'd0,  F, F, F, F, Z32,         Z32,          F};
        vecs[3]  = '{T, 32'h104,  LW5,  32'h10,      Z32,          F, Z32,           T, Z32,  F, Z32,          5'd0,  T, F, T, F, 32'h10,      Z32,          F};
        vecs[4]  = '{T, 32'h104,  LW5,  32'h10,      Z32,          F, Z32,           T, Z32,  F, Z32,          5'd0,  T, F, T, F, 32'h10,      Z32,          F};
        vecs[5]  = '{T, 32'h104,  LW5,  32'h10,      Z32,          T, 32'hDEADBEEF,  F, LW5,  T, 32'hDEADBEEF, 5'd5,  T, T, T, F, 32'h10,      Z32,          F};
        vecs[6]  = '{T, 32'h108,  SW2,  32'h3FF,     32'h12345678, F, Z32,           T, Z32,  F, Z32,          5'd0,  F, F, F, F, Z32,         Z32,          F};
        vecs[7]  = '{T, 32'h108,  SW2,  32'h3FF,     32'h12345678, T, 32'h5A5A5A5A,  F, SW2,  T, 32'h3FF,      5'd0,  T, F, T, T, 32'h3FF,     32'h12345678, F};
        vecs[8]  = '{T, 32'h10C,  JAL,  32'h200,     Z32,          F, Z32,           F, JAL,  T, 32'h200,      5'd31, T, T, F, F, Z32,         Z32,          F};
        vecs[9]  = '{T, 32'h110,  SETX, 32'h55,      Z32,          F, Z32,           F, SETX, T, 32'h55,       5'd30, T, T, F, F, Z32,         Z32,          F};
        vecs[10] = '{F, 32'h114,  Z32,  32'h77,      Z32,          T, 32'h99,        F, Z32,  T, Z32,          5'd0,  T, F, F, F, Z32,         Z32,          F};
        vecs[11] = '{T, 32'h118,  LW5,  32'h20,      Z32,          F, Z32,           T, Z32,  F, Z32,          5'd0,  F, F, F, F, Z32,         Z32,          F};
        vecs[12] = '{T, 32'h118,  LW5,  32'h20,      Z32,          T, 32'h11111111,  F, LW5,  T, 32'h11111111, 5'd5,  T, T, T, F, 32'h20,      Z32,          F};
        vecs[13] = '{T, 32'h11C,  LW6,  32'h30,      Z32,          F, Z32,           T, Z32,  F, Z32,          5'd0,  F, F, F, F, Z32,         Z32,          F};
        vecs[14] = '{T, 32'h11C,  LW6,  32'h30,      Z32,          T, 32'h22222222,  F, LW6,  T, 32'h22222222, 5'd6,  T, T, T, F, 32'h30,      Z32,          F};

        do_reset();

        // Directed table
        for (int i = 0; i < 15; i++) begin
            drive(F, vecs[i].vin, vecs[i].pc, vecs[i].ins, vecs[i].alu, vecs[i].sd, vecs[i].rdy, vecs[i].rdata);
            #3;
            chk($sformatf("v%0d_stall", i), 32'(stall_out), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_ins", i), Instruction_out, vecs[i].e_ins);
            if (vecs[i].c_wd) chk($sformatf("v%0d_wd", i), wdata_out, vecs[i].e_wd);
            chk($sformatf("v%0d_rd", i), 32'(Rd_XM_bypass), 32'(vecs[i].e_rd));
            if (vecs[i].c_bv) chk($sformatf("v%0d_bv", i), 32'(bypass_valid), 32'(vecs[i].e_bv));
            chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].e_we));
                chk($sformatf("v%0d_addr", i), 32'(dmem_addr), vecs[i].e_addr);
                if (vecs[i].e_we) chk($sformatf("v%0d_mwd", i), dmem_wdata, vecs[i].e_mwd);
            end
            chk($sformatf("v%0d_err", i), 32'(mem_err), 32'(vecs[i].e_err));
            tick();
        end

        // Timeout: memory never answers
        drive(F, T, 32'h200, LW7, 32'h44, Z32, F, Z32);
        #3; chk("to_issue_stall", 32'(stall_out), 32'(1)); tick();
        nreq = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            drive(F, T, 32'h200, LW7, 32'h44, Z32, F, Z32);
            #3;
            if (dmem_req) nreq++;
            if (dmem_req && !stall_out) begin
                done = 1;
                chk("to_wd", wdata_out, Z32);
                chk("to_ins", Instruction_out, LW7);
                chk("to_pc", PC_out, 32'h200);
                chk("to_rd", 32'(Rd_XM_bypass), 32'(7));
            end
            tick();
        end
        chk("to_done", 32'(done), 32'(1));
        chk("to_req_cycles", 32'(nreq), 32'(MAXW + 1));
        for (int i = 0; i < 3; i++) begin
            drive(F, T, 32'h204 + 32'(4 * i), ADD3, 32'(i + 9), Z32, F, Z32);
            #3;
            chk("to_err_sticky", 32'(mem_err), 32'(1));
            chk("to_add_wd", wdata_out, 32'(i + 9));
            tick();
        end

        // Reset pulsed mid-access clears mem_err and abandons the request
        drive(F, T, 32'h300, LW5, 32'h55, Z32, F, Z32); #3; tick();
        drive(F, T, 32'h300, LW5, 32'h55, Z32, F, Z32); #3;
        chk("rst_req_before", 32'(dmem_req), 32'(1)); tick();
        drive(T, T, 32'h300, LW5, 32'h55, Z32, F, Z32); #3;
        chk("rst_req_during", 32'(dmem_req), 32'(1)); tick();
        drive(F, F, Z32, Z32, Z32, Z32, F, Z32); #3;
        chk("rst_req_after", 32'(dmem_req), 32'(0));
        chk("rst_stall_after", 32'(stall_out), 32'(0));
        chk("rst_err_after", 32'(mem_err), 32'(0));
        tick();

        // Ready arrives in the same cycle the wait counter hits its limit
        drive(F, T, 32'h400, LW9, 32'hAB, Z32, F, Z32); #3; tick();
        for (int i = 0; i < int'(MAXW); i++) begin
            drive(F, T, 32'h400, LW9, 32'hAB, Z32, F, Z32); #3;
            chk("lim_stall", 32'(stall_out), 32'(1));
            tick();
        end
        drive(F, T, 32'h400, LW9, 32'hAB, Z32, T, 32'hCAFEF00D); #3;
        chk("lim_stall_done", 32'(stall_out), 32'(0));
        chk("lim_wd", wdata_out, 32'hCAFEF00D);
        chk("lim_rd", 32'(Rd_XM_bypass), 32'(9));
        tick();
        drive(F, F, Z32, Z32, Z32, Z32, F, Z32); #3;
        chk("lim_err", 32'(mem_err), 32'(0));
        chk("lim_req", 32'(dmem_req), 32'(0));
        tick();

        // Random traffic against the reference model
        do_reset();
        m_busy = 0; m_waited = 0; m_err = 0;
        m_pc = '0; m_ins = '0; m_sd = '0; m_addr = '0;
        rdy_pct = 30;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdy_pct = 2;
                    1:       rdy_pct = 30;
                    default: rdy_pct = 70;
                endcase
            end
            case ($urandom_range(0, 6))
                0, 1:    op = OP_LW;
                2:       op = OP_SW;
                3:       op = OP_JAL;
                4:       op = OP_SETX;
                default: op = 5'($urandom);
            endcase
            ins = {op, 27'($urandom)};
            if ($urandom_range(0, 30) == 0) ins = Z32;
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), $urandom, ins,
                  $urandom, $urandom, ($urandom_range(0, 99) < rdy_pct), $urandom);
            #3;
            model_check();
            @(posedge clk);
            model_update();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
